// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I fetch constants and fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int                C_XLEN             = 32;
    localparam logic [C_XLEN-1:0] C_NOP_INSTR        = 32'h0000_0013;
    localparam logic [C_XLEN-1:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Instruction-memory and IF/ID handshake bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    import rv32_pkg::*;

    logic [C_XLEN-1:0] imem_pc;
    logic [C_XLEN-1:0] imem_instr;
    logic              id_valid;
    logic              id_ready;
    logic [C_XLEN-1:0] id_pc;
    logic [C_XLEN-1:0] id_instr;

    modport master (
        output imem_pc,
        input  imem_instr,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_instr
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_instr
    );

endinterface
`default_nettype wire

// File: rtl/fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if_id_reg
// Description : IF/ID valid/ready holding register with flush; NOP when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_if_id_reg
    import rv32_pkg::*;
(
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_flush,
    input  wire                i_load,
    input  wire  [C_XLEN-1:0]  i_pc,
    input  wire  [C_XLEN-1:0]  i_instr,
    input  wire                i_ready,
    output logic               o_valid,
    output logic [C_XLEN-1:0]  o_pc,
    output logic [C_XLEN-1:0]  o_instr
);

    logic              valid_q, valid_d;
    logic [C_XLEN-1:0] pc_q, pc_d;
    logic [C_XLEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        // Flush outranks a capture; an emptied entry always reads back as NOP.
        if (i_flush) begin
            valid_d = 1'b0;
            instr_d = C_NOP_INSTR;
        end else if (i_load) begin
            valid_d = 1'b1;
            pc_d    = i_pc;
            instr_d = i_instr;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
            instr_d = C_NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= C_NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : RV32I fetch controller: PC, BOOT/RUN/HALT FSM, redirect/flush,
//               handshake counter. Define FETCH_MISALIGN_CHK_EN to halt and flag
//               misaligned redirects instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [C_XLEN-1:0] RESET_PC = C_DEFAULT_RESET_PC
) (
    input  wire                clk,
    input  wire                rst_n,
    fetch_ctrl_if.master       bus,
    input  wire                redirect_valid,
    input  wire  [C_XLEN-1:0]  redirect_pc,
    input  wire                halt_req,
    input  wire                resume_req,
    output logic               halted,
    output logic               misalign_err,
    output logic [C_XLEN-1:0]  fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [C_XLEN-1:0] pc_q, pc_d;
    logic [C_XLEN-1:0] fetch_count_q, fetch_count_d;
    logic              misalign_q, misalign_d;

    logic              w_redirect;
    logic              w_fire;
    logic              w_handshake;
    logic              w_misalign;
    logic [C_XLEN-1:0] w_redirect_tgt;

    assign w_redirect  = redirect_valid && (state_q != ST_BOOT);
    // A pending halt suppresses the capture on its own edge.
    assign w_fire      = (state_q == ST_RUN) && (!bus.id_valid || bus.id_ready)
                         && !redirect_valid && !halt_req;
    assign w_handshake = bus.id_valid && bus.id_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_redirect_tgt = redirect_pc;
    assign w_misalign     = w_redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;
    assign w_misalign     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (resume_req) begin
                    state_d    = ST_RUN;
                    misalign_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (w_misalign) begin
            state_d    = ST_HALT;
            misalign_d = 1'b1;
        end

        if (w_redirect)  pc_d = w_redirect_tgt;
        else if (w_fire) pc_d = pc_q + 32'd4;

        if (w_handshake) fetch_count_d = fetch_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_redirect),
        .i_load  (w_fire),
        .i_pc    (pc_q),
        .i_instr (bus.imem_instr),
        .i_ready (bus.id_ready),
        .o_valid (bus.id_valid),
        .o_pc    (bus.id_pc),
        .o_instr (bus.id_instr)
    );

    assign bus.imem_pc   = pc_q;
    assign halted        = (state_q == ST_HALT);
    assign misalign_err  = misalign_q;
    assign fetch_count   = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_w_n = 1'b0;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        halted, misalign_err;
    logic [31:0] fetch_count;
    logic        halted_w, misalign_w;
    logic [31:0] fetch_count_w;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: 0=boot, 1=run, 2=halt
    int          m_st;
    logic [31:0] m_pc, m_idpc, m_idinstr, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0000_0013;
            32'd4:   return 32'h0010_0093;
            32'd8:   return 32'h0020_0113;
            32'd12:  return 32'h0030_8193;
            default: return a * 32'h9E37_79B1 + 32'h1;
        endcase
    endfunction

    fetch_ctrl_if bus();
    fetch_ctrl_if bus_w();

    assign bus.imem_instr   = imem(bus.imem_pc);
    assign bus.id_ready     = id_ready;
    assign bus_w.imem_instr = imem(bus_w.imem_pc);
    assign bus_w.id_ready   = 1'b1;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .resume_req(resume_req),
        .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .bus(bus_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .halt_req(1'b0), .resume_req(1'b0),
        .halted(halted_w), .misalign_err(misalign_w), .fetch_count(fetch_count_w)
    );

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_valid = 1'b0; m_idpc = 32'h0;
        m_idinstr = 32'h13; m_cnt = 32'h0; m_mis = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs presently driven.
    task automatic model_step();
        logic        red, fire, hs, mis;
        logic [31:0] tgt;
        int          nst;
        red  = redirect_valid && (m_st != 0);
        fire = (m_st == 1) && (!m_valid || id_ready) && !redirect_valid && !halt_req;
        hs   = m_valid && id_ready;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = redirect_pc;
        mis = red && (redirect_pc % 4 != 0);
`else
        tgt = (redirect_pc / 4) * 4;
        mis = 1'b0;
`endif
        if (hs) m_cnt = m_cnt + 1;
        if (red) begin
            m_valid = 1'b0; m_idinstr = 32'h13;
        end else if (fire) begin
            m_valid = 1'b1; m_idpc = m_pc; m_idinstr = imem(m_pc);
        end else if (hs) begin
            m_valid = 1'b0; m_idinstr = 32'h13;
        end
        if (red) m_pc = tgt;
        else if (fire) m_pc = m_pc + 4;
        nst = m_st;
        if (m_st == 0) nst = 1;
        else if (m_st == 1 && halt_req) nst = 2;
        else if (m_st == 2 && resume_req) begin nst = 1; m_mis = 1'b0; end
        if (mis) begin nst = 2; m_mis = 1'b1; end
        m_st = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
        halt_req = 1'b0; resume_req = 1'b0; redirect_pc = '0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_pc, halted, misalign_err, fetch_count}
            !== {1'b0, 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_values got v=%b pc=%h ins=%h ipc=%h h=%b m=%b cnt=%0d",
                     bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_pc, halted, misalign_err, fetch_count);
        end
        tick();
        n_cmp++;
        if (bus.id_valid !== 1'b0) begin
            n_bad++; $display("FAIL boot_no_valid got %b exp 0", bus.id_valid);
        end
    endtask

    task automatic test_sequence();
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'(i * 4), imem(32'(i * 4))}) begin
                n_bad++;
                $display("FAIL seq_%0d got v=%b pc=%h ins=%h exp pc=%h", i, bus.id_valid, bus.id_pc,
                         bus.id_instr, 32'(i * 4));
            end
        end
        n_cmp++;
        if (fetch_count !== 32'd4) begin
            n_bad++; $display("FAIL seq_count got %0d exp 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        id_ready = 1'b1;
        tick(); tick(); tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_pc}
                !== {1'b1, 32'h4, 32'h0010_0093, 32'h8}) begin
                n_bad++;
                $display("FAIL stall_%0d got v=%b pc=%h ins=%h ipc=%h", i, bus.id_valid, bus.id_pc,
                         bus.id_instr, bus.imem_pc);
            end
        end
        id_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.id_valid, bus.id_pc, bus.id_instr} !== {1'b1, 32'h8, 32'h0020_0113}) begin
            n_bad++;
            $display("FAIL stall_release got v=%b pc=%h ins=%h exp pc=8", bus.id_valid, bus.id_pc, bus.id_instr);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] c0;
        c0 = m_cnt;
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0; id_ready = 1'b1;
        n_cmp++;
        if ({bus.id_valid, bus.id_instr, bus.imem_pc, fetch_count} !== {1'b0, 32'h13, 32'h0, c0}) begin
            n_bad++;
            $display("FAIL redirect_flush got v=%b ins=%h ipc=%h cnt=%0d exp cnt=%0d", bus.id_valid,
                     bus.id_instr, bus.imem_pc, fetch_count, c0);
        end
        tick();
        n_cmp++;
        if ({bus.id_valid, bus.id_pc, bus.id_instr, fetch_count} !== {1'b1, 32'h0, 32'h13, c0}) begin
            n_bad++;
            $display("FAIL redirect_target got v=%b pc=%h ins=%h cnt=%0d", bus.id_valid, bus.id_pc,
                     bus.id_instr, fetch_count);
        end
    endtask

    task automatic test_halt();
        logic [31:0] p;
        p = m_pc;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++; $display("FAIL halt_enter got %b exp 1", halted);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({bus.id_valid, bus.imem_pc, halted} !== {1'b0, p, 1'b1}) begin
                n_bad++;
                $display("FAIL halt_idle_%0d got v=%b ipc=%h h=%b exp ipc=%h", i, bus.id_valid,
                         bus.imem_pc, halted, p);
            end
        end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        tick();
        n_cmp++;
        if ({bus.id_valid, bus.id_pc, halted} !== {1'b1, p, 1'b0}) begin
            n_bad++;
            $display("FAIL resume got v=%b pc=%h h=%b exp pc=%h", bus.id_valid, bus.id_pc, halted, p);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({halted, misalign_err, bus.imem_pc} !== {1'b1, 1'b1, 32'h6}) begin
                n_bad++;
                $display("FAIL misalign_hold_%0d got h=%b m=%b ipc=%h", i, halted, misalign_err, bus.imem_pc);
            end
            tick();
        end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        n_cmp++;
        if ({halted, misalign_err} !== 2'b00) begin
            n_bad++; $display("FAIL misalign_clear got h=%b m=%b exp 0 0", halted, misalign_err);
        end
`else
        n_cmp++;
        if ({bus.imem_pc, misalign_err, halted} !== {32'h4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL misalign_align got ipc=%h m=%b h=%b exp ipc=4", bus.imem_pc, misalign_err, halted);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_ready       = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 10) == 0;
            redirect_pc    = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom % 64;
            halt_req       = ($urandom % 20) == 0;
            resume_req     = ($urandom % 5) == 0;
            tick();
            n_cmp++;
            if ({bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_pc, halted, misalign_err, fetch_count}
                !== {m_valid, m_idpc, m_idinstr, m_pc, m_st == 2, m_mis, m_cnt}) begin
                n_bad++;
                $display("FAIL random_%0d got v=%b pc=%h ins=%h ipc=%h h=%b m=%b cnt=%0d exp v=%b pc=%h ins=%h ipc=%h h=%b m=%b cnt=%0d",
                         cyc, bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_pc, halted, misalign_err,
                         fetch_count, m_valid, m_idpc, m_idinstr, m_pc, m_st == 2, m_mis, m_cnt);
            end
        end
        // Asynchronous reset taken mid-cycle, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.id_valid, bus.id_instr, bus.imem_pc, halted, misalign_err, fetch_count}
            !== {1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL async_reset got v=%b ins=%h ipc=%h h=%b m=%b cnt=%0d", bus.id_valid,
                     bus.id_instr, bus.imem_pc, halted, misalign_err, fetch_count);
        end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        rst_w_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus_w.id_valid !== 1'b0) begin
            n_bad++; $display("FAIL wrap_boot got v=%b exp 0", bus_w.id_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_w.id_valid, bus_w.id_pc, bus_w.id_instr} !== {1'b1, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC)}) begin
            n_bad++; $display("FAIL wrap_top got v=%b pc=%h exp pc=fffffffc", bus_w.id_valid, bus_w.id_pc);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_w.id_valid, bus_w.id_pc, bus_w.id_instr} !== {1'b1, 32'h0, 32'h13}) begin
            n_bad++; $display("FAIL wrap_zero got v=%b pc=%h exp pc=0", bus_w.id_valid, bus_w.id_pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_halt();
        test_misalign();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the RV32I pipelined core. It owns the program counter and drives the combinational instruction memory with it. It registers each fetched word into the IF/ID stage under a valid/ready handshake with decode. It applies branch/jump redirects with flush, supports halt/resume, and counts retired fetches.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- imem_pc  out  32: fetch address to the instruction memory; equals pc_q combinationally.
- imem_instr  in  32: instruction word returned combinationally for imem_pc.
- id_valid  out  1: IF/ID register holds a valid instruction.
- id_ready  in  1: decode accepts the IF/ID contents this cycle.
- id_pc  out  32: PC of the instruction in IF/ID.
- id_instr  out  32: instruction in IF/ID; 32'h0000_0013 (NOP) whenever id_valid=0.
- redirect_valid  in  1: single-cycle request to change the PC (taken branch/jump from EX).
- redirect_pc  in  32: redirect target.
- halt_req  in  1: stop fetching.
- resume_req  in  1: leave HALT.
- halted  out  1: state is HALT.
- misalign_err  out  1: sticky misaligned-redirect flag (see Configuration).
- fetch_count  out  32: number of id_valid&&id_ready handshakes.

## Operation
- States: BOOT, RUN, HALT. Reset gives BOOT. BOOT moves to RUN unconditionally on the next edge. RUN moves to HALT on halt_req. HALT moves to RUN on resume_req.
- Define fire = state==RUN && (!id_valid || id_ready) && !redirect_valid.
- On fire, IF/ID captures {1, pc_q, imem_instr} and pc_q advances by 4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- When id_valid && id_ready && !fire, id_valid clears.
- When id_valid && !id_ready, IF/ID and pc_q hold, with no loss or duplication.
- redirect_valid has the highest priority below reset and is accepted in any state except BOOT, where it is ignored.
  - pc_q takes redirect_pc.
  - IF/ID is flushed: id_valid=0 and id_instr=NOP.
  - The same-cycle imem_instr is discarded.
- halt_req together with redirect_valid: the redirect is applied and the state becomes HALT.
- halt_req together with resume_req in HALT: resume wins.
- In HALT nothing is fetched. A valid IF/ID entry stays valid until decode consumes it.
- fetch_count increments on every id_valid&&id_ready, including in HALT, and wraps at 2^32.
- halted = (state==HALT).

## Timing
- Reset values: pc_q=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP, halted=0, misalign_err=0, fetch_count=0, state=BOOT.
- The first instruction, RESET_PC, is valid two edges after rst_n rises (one edge for BOOT, one edge for the capture).
- Fetch latency is one cycle from pc_q to id_valid. Throughput is one instruction per cycle while id_ready=1.
- Redirect asserted in cycle N: pc_q=target and id_valid=0 in N+1; the target instruction is valid in N+2 (one bubble).
- halt_req in cycle N: no capture at edge N; halted=1 from N+1.
- resume_req in cycle N: fetch resumes at edge N+1; the next instruction is valid in N+2.
- Reset asserted mid-operation forces all reset values asynchronously. Any in-flight IF/ID entry is dropped.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 is applied as usual.
  - The state is forced to HALT and misalign_err is set.
  - misalign_err stays high until resume_req is accepted in HALT, which clears it.
- FETCH_MISALIGN_CHK_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded into pc_q.
  - misalign_err is tied to 0.
  - The port exists in both builds.

## Structure
- Shared package rv32_pkg holds:
  - the NOP constant (32'h0000_0013);
  - the fetch state enum (BOOT/RUN/HALT);
  - the XLEN=32 constant;
  - the default reset-PC localparam.
- One natural sub-module, fetch_if_id_reg: the IF/ID valid/ready holding register with flush input.
- PC, state machine and counter live in fetch_ctrl.

## Test plan
- Reset release with imem preloaded 0x13, 0x00100093, 0x00200113, 0x00308193; id_ready=1. Expected: id_valid=0 in the first cycle; id_pc 0, 4, 8, 12 with matching words on consecutive cycles; fetch_count=4 after four handshakes.
- Stall: id_ready=0 for 3 cycles while holding pc 4. Expected: id_pc=4 and id_instr=0x00100093 stable; imem_pc=8 stable; after release, pc 8 follows with no duplicate.
- Redirect to 0x0 while id_pc=8 is valid. Expected: next cycle id_valid=0 and id_instr=NOP; the following cycle id_pc=0; fetch_count unchanged by the flushed entry.
- Halt, then resume. Expected: halted=1 the cycle after halt_req; no new fetches for 5 cycles; resume_req gives the next sequential PC valid two cycles later.
- Wrap-around: RESET_PC=32'hFFFF_FFFC. Expected: id_pc=FFFF_FFFC, then id_pc=0.
- With FETCH_MISALIGN_CHK_EN: redirect to 0x6. Expected: halted=1 and misalign_err=1 until resume_req clears it. Without the macro: pc_q=0x4 and misalign_err=0.
